adder_operand_fifo: RTL and testbench
=====================================

ADDER_OPERAND_FIFO -- requirements
Module: adder_operand_fifo

Interface
REQ-001 Parameter SIZE, default 32: operand width in bits, matching the 32-bit Sklansky adder it feeds.
REQ-002 Parameter DEPTH, default 4: entry count; power of two, >= 2.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 in_valid  input  1  producer presents an operand set.
REQ-006 in_ready  output  1  FIFO can accept an entry this cycle.
REQ-007 in_a, in_b  input  SIZE each  operands.
REQ-008 in_cin  input  1  carry-in.
REQ-009 out_valid  output  1  head entry valid toward the adder.
REQ-010 out_ready  input  1  adder side consumes head this cycle.
REQ-011 out_a, out_b  output  SIZE each  head operands, wired to adder a, b.
REQ-012 out_cin  output  1  head carry-in, wired to adder cin.
REQ-013 count  output  $clog2(DEPTH+1)  stored entries.

Function
REQ-014 Push = in_valid && in_ready; pop = out_valid && out_ready; the triple {a, b, cin} moves as one entry.
REQ-015 in_ready = (count != DEPTH); no combinational path from out_ready to in_ready.
REQ-016 out_valid = (count != 0), first-word-fall-through: head entry drives out_* with no extra cycle.
REQ-017 A pushed entry appears on out_* the cycle after the push when the FIFO was empty (latency 1, bypass off).
REQ-018 out_a, out_b, out_cin are 0 whenever out_valid is 0.
REQ-019 Push only: count +1; pop only: count -1; push and pop together: count unchanged, head advances, new entry stored.
REQ-020 Write and read pointers wrap modulo DEPTH; entry order is strictly FIFO across wrap-around.
REQ-021 Full: in_ready 0, in_valid ignored, storage unchanged, even if out_ready is 1 that cycle.
REQ-022 Empty: out_ready ignored, count never goes below 0.
REQ-023 out_* and out_valid hold steady while out_valid && !out_ready.

Reset
REQ-024 rst_n low: count 0, both pointers 0, out_valid 0, out_a/out_b/out_cin 0, in_ready 1, immediately and without a clock edge.
REQ-025 Reset mid-operation discards all stored entries; the first push after rst_n rises is the next entry output.
REQ-026 Storage array contents need no reset; stale data is never visible on out_* (REQ-018).

Configuration
REQ-027 Macro ADDER_FIFO_BYPASS_EN defined: when count == 0, in_valid == 1 and out_ready == 1, out_valid = 1 and out_* = in_* in the same cycle; the entry is consumed without storage and count stays 0.
REQ-028 With ADDER_FIFO_BYPASS_EN defined and count == 0 but out_ready == 0, the entry is stored normally and out_valid stays 0 that cycle.
REQ-029 Macro undefined: no bypass path; behaviour exactly per REQ-014..REQ-023.

Verification
REQ-030 Reset then push a=0x0000_0001, b=0x0000_0002, cin=1 with out_ready=0 -> next cycle out_valid=1, out_a=1, out_b=2, out_cin=1, count=1.
REQ-031 Push 4 entries (a=1..4, b=0) with out_ready=0 -> count=4, in_ready=0; 5th push (a=5) rejected; then drain -> out_a sequence 1,2,3,4, then out_valid=0, out_a=0.
REQ-032 At count=2, push and pop in the same cycle for 10 cycles (a=10..19) -> count stays 2, outputs in push order across pointer wrap.
REQ-033 Full FIFO, out_ready=1 and in_valid=1 in one cycle -> pop occurs, push refused, count=3.
REQ-034 Assert rst_n=0 asynchronously at count=3 -> out_valid=0, count=0, in_ready=1 before the next clock edge; after release, push a=0xFFFF_FFFF -> that value is the next output.
REQ-035 With ADDER_FIFO_BYPASS_EN, empty FIFO, in_valid=1, out_ready=1, a=0x8000_0000 -> same cycle out_valid=1, out_a=0x8000_0000, count=0; without the macro -> out_valid=0 that cycle, count=1.

Source files
------------

// File: rtl/adder_operand_fifo.sv
// Operand FIFO feeding a Sklansky adder: {a, b, cin} triples, first-word-fall-through.
// Optional same-cycle empty-FIFO bypass is enabled by defining ADDER_FIFO_BYPASS_EN.
module adder_operand_fifo #(
  parameter int SIZE  = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [SIZE-1:0]            in_a,
  input  logic [SIZE-1:0]            in_b,
  input  logic                       in_cin,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [SIZE-1:0]            out_a,
  output logic [SIZE-1:0]            out_b,
  output logic                       out_cin,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = $clog2(DEPTH+1);
  localparam int ENTRY_W = 2*SIZE + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  typedef logic [ENTRY_W-1:0] entry_t;

  entry_t           mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic   full, empty;
  logic   push, pop;
  logic   store, retire;
  logic   bypass;
  entry_t in_entry, head_entry, out_entry;

  // DEPTH is a power of two, so the natural PTR_W-bit rollover is the modulo wrap.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return p + PTR_W'(1);
  endfunction

  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);

`ifdef ADDER_FIFO_BYPASS_EN
  assign bypass = empty && in_valid && out_ready;
`else
  assign bypass = 1'b0;
`endif

  // in_ready depends on stored count only, keeping out_ready off this path.
  assign in_ready  = !full;
  assign out_valid = !empty || bypass;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // A bypassed entry goes straight through and touches neither storage nor count.
  assign store  = push && !bypass;
  assign retire = pop && !bypass;

  assign in_entry   = {in_a, in_b, in_cin};
  assign head_entry = mem_q[rd_ptr_q];

  always_comb begin
    out_entry = '0;
    if (bypass) begin
      out_entry = in_entry;
    end else if (!empty) begin
      out_entry = head_entry;
    end
  end

  assign {out_a, out_b, out_cin} = out_entry;
  assign count = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (store) begin
      wr_ptr_d = ptr_inc(wr_ptr_q);
    end
    if (retire) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    case ({store, retire})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is never reset; out_* masking keeps stale words invisible.
  always_ff @(posedge clk) begin
    if (store) begin
      mem_q[wr_ptr_q] <= in_entry;
    end
  end

endmodule

// File: tb/tb_adder_operand_fifo.sv
// Randomized and directed bench for adder_operand_fifo against a queue-based reference model.
// Define ADDER_FIFO_BYPASS_EN for both files to exercise the bypass build.
module tb_adder_operand_fifo;
  localparam int SIZE  = 32;
  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH+1);

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [SIZE-1:0]  in_a, in_b;
  logic             in_cin;
  logic             out_valid;
  logic             out_ready;
  logic [SIZE-1:0]  out_a, out_b;
  logic             out_cin;
  logic [CNT_W-1:0] count;

  adder_operand_fifo #(.SIZE(SIZE), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_a(out_a), .out_b(out_b), .out_cin(out_cin),
    .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [SIZE-1:0] a;
    logic [SIZE-1:0] b;
    logic            cin;
  } ent_t;

  ent_t model_q[$];
  int   n_cmp = 0;
  int   n_mis = 0;

`ifdef ADDER_FIFO_BYPASS_EN
  localparam bit BYPASS_EN = 1'b1;
`else
  localparam bit BYPASS_EN = 1'b0;
`endif

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Called at a negedge: drive, compare against model, advance model across posedge.
  task automatic step(input logic v, input logic [SIZE-1:0] a, input logic [SIZE-1:0] b,
                      input logic c, input logic r);
    ent_t head;
    logic byp, exp_v, push_ok, pop_ok;
    in_valid = v; in_a = a; in_b = b; in_cin = c; out_ready = r;
    #1;
    byp   = BYPASS_EN && (model_q.size() == 0) && v && r;
    exp_v = (model_q.size() != 0) || byp;
    head  = '0;
    if (byp) begin
      head.a = a; head.b = b; head.cin = c;
    end else if (model_q.size() != 0) begin
      head = model_q[0];
    end
    check("out_valid", out_valid, exp_v);
    check("in_ready", in_ready, model_q.size() != DEPTH);
    check("count", count, model_q.size());
    check("out_a", out_a, head.a);
    check("out_b", out_b, head.b);
    check("out_cin", out_cin, head.cin);
    push_ok = v && (model_q.size() != DEPTH);
    pop_ok  = exp_v && r;
    @(posedge clk);
    if (!byp) begin
      if (pop_ok) void'(model_q.pop_front());
      if (push_ok) begin
        ent_t e;
        e.a = a; e.b = b; e.cin = c;
        model_q.push_back(e);
      end
    end
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; out_ready = 1'b0;
    #1;
    check("rst_count", count, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_a", out_a, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Single push with consumer stalled
    step(1'b1, 32'h1, 32'h2, 1'b1, 1'b0);
    check("p1_valid", out_valid, 1);
    check("p1_a", out_a, 32'h1);
    check("p1_b", out_b, 32'h2);
    check("p1_cin", out_cin, 1);
    check("p1_count", count, 1);
    step(1'b0, '0, '0, 1'b0, 1'b1);

    // Fill, reject extra push, drain in order
    for (int i = 1; i <= 4; i++) step(1'b1, SIZE'(i), '0, 1'b0, 1'b0);
    check("full_count", count, 4);
    check("full_in_ready", in_ready, 0);
    step(1'b1, 32'h5, '0, 1'b0, 1'b0);
    check("reject_count", count, 4);
    for (int i = 1; i <= 4; i++) begin
      check("drain_a", out_a, i);
      step(1'b0, '0, '0, 1'b0, 1'b1);
    end
    check("drained_valid", out_valid, 0);
    check("drained_a", out_a, 0);

    // Steady push+pop at count 2 across pointer wrap
    step(1'b1, 32'd100, '0, 1'b0, 1'b0);
    step(1'b1, 32'd101, '0, 1'b1, 1'b0);
    for (int i = 10; i < 20; i++) begin
      step(1'b1, SIZE'(i), SIZE'(i * 3), i[0], 1'b1);
      check("pp_count", count, 2);
    end
    check("pp_head", out_a, 18);

    // Full with simultaneous push+pop: pop only
    step(1'b1, 32'd30, '0, 1'b0, 1'b0);
    step(1'b1, 32'd31, '0, 1'b0, 1'b0);
    check("full2_count", count, 4);
    step(1'b1, 32'd32, '0, 1'b0, 1'b1);
    check("fullpp_count", count, 3);

    // Asynchronous reset mid-operation
    in_valid = 1'b0; out_ready = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check("arst_out_valid", out_valid, 0);
    check("arst_count", count, 0);
    check("arst_in_ready", in_ready, 1);
    check("arst_out_a", out_a, 0);
    model_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    step(1'b1, 32'hFFFF_FFFF, '0, 1'b0, 1'b0);
    check("post_rst_a", out_a, 32'hFFFF_FFFF);
    step(1'b0, '0, '0, 1'b0, 1'b1);

    // Empty FIFO with producer and consumer both active
    in_valid = 1'b1; in_a = 32'h8000_0000; in_b = '0; in_cin = 1'b0; out_ready = 1'b1;
    #1;
`ifdef ADDER_FIFO_BYPASS_EN
    check("byp_valid", out_valid, 1);
    check("byp_a", out_a, 32'h8000_0000);
`else
    check("byp_valid", out_valid, 0);
    check("byp_a", out_a, 0);
`endif
    check("byp_count_now", count, 0);
    step(1'b1, 32'h8000_0000, '0, 1'b0, 1'b1);
`ifdef ADDER_FIFO_BYPASS_EN
    check("byp_count_after", count, 0);
`else
    check("byp_count_after", count, 1);
`endif
    step(1'b0, '0, '0, 1'b0, 1'b1);

    // Randomized traffic with shifting producer/consumer bias
    for (int phase = 0; phase < 4; phase++) begin
      int pv, pr;
      pv = (phase == 1) ? 85 : (phase == 2) ? 25 : 60;
      pr = (phase == 1) ? 25 : (phase == 2) ? 85 : 60;
      for (int n = 0; n < 150; n++) begin
        step(($urandom_range(99) < pv), $urandom, $urandom, $urandom_range(1) == 1,
             ($urandom_range(99) < pr));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
